// File: rtl/ddr_datapath_read_pkg.sv
// ----------------------------------------------------------------------------
// ddr_datapath_read_pkg
// Shared definitions for the DDR read datapath:
//   - command FSM state codes (mirrors the controller's DDR_parameters.v);
//     only C_WAIT_END_OF_R_BURST is consumed by the read path
//   - encoding of the read datapath FSM states
// ----------------------------------------------------------------------------
package ddr_datapath_read_pkg;

  // Controller command FSM codes, as driven on cmd_state.
  localparam logic [3:0] C_IDLE                = 4'd0;
  localparam logic [3:0] C_ACTIVATE            = 4'd1;
  localparam logic [3:0] C_WRITE               = 4'd2;
  localparam logic [3:0] C_WAIT_END_OF_W_BURST = 4'd3;
  localparam logic [3:0] C_READ                = 4'd4;
  localparam logic [3:0] C_WAIT_END_OF_R_BURST = 4'd5;
  localparam logic [3:0] C_PRECHARGE           = 4'd6;
  localparam logic [3:0] C_REFRESH             = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_CL  = 3'd1,
    ST_PREAMBLE = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_DONE     = 3'd4
  } rd_state_e;

endpackage

// File: rtl/ddr_datapath_read_word_pack.sv
// ----------------------------------------------------------------------------
// ddr_rd_word_pack
// Packs consecutive bytes into 16-bit words, first byte in [15:8].
// Tracks the byte-index LSB itself; clear forces the next byte to be treated
// as a high byte (used at burst start and on abort, discarding any half word).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clear           restart pairing at the high byte
//   byte_en         byte_data holds a burst byte this cycle
//   byte_data       captured byte
//   sys_data_r      last assembled word, held until the next one
//   rd_valid        one-cycle pulse: sys_data_r just updated
// ----------------------------------------------------------------------------
module ddr_rd_word_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [15:0] sys_data_r,
  output logic        rd_valid
);

  logic       odd;
  logic [7:0] hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      odd        <= 1'b0;
      hi         <= '0;
      sys_data_r <= '0;
      rd_valid   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (clear) begin
        odd <= 1'b0;
      end else if (byte_en) begin
        odd <= ~odd;
        if (!odd) begin
          hi <= byte_data;
        end else begin
          sys_data_r <= {hi, byte_data};
          rd_valid   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ddr_datapath_read.sv
// ----------------------------------------------------------------------------
// ddr_datapath_read
// Read-direction DDR datapath: registers the DRAM data bus and strobe, waits
// out CAS latency, detects the DQS preamble (low then high), captures
// BURST_LEN bytes and emits them as 16-bit words, high byte first.
// Optional build macro READ_TIMEOUT_EN: abort after TIMEOUT cycles in
// PREAMBLE without a valid preamble. Without it PREAMBLE waits indefinitely.
// Parameters:
//   CAS_LAT    cycles from rd_start to the first preamble check (1..15)
//   BURST_LEN  bytes per burst, even (2..16)
//   TIMEOUT    PREAMBLE cycle limit (READ_TIMEOUT_EN builds only)
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   rd_start    read command issued this cycle (accepted only in IDLE)
//   cmd_state   controller command state; leaving C_WAIT_END_OF_R_BURST
//               during PREAMBLE/CAPTURE aborts the burst
//   ddr_dq_r    DRAM read data, ddr_dqs_r DRAM read strobe
//   sys_data_r  assembled word, rd_valid its one-cycle valid pulse
//   rd_done     burst completed, rd_err burst aborted (one-cycle pulses)
//   busy        FSM not IDLE
// ----------------------------------------------------------------------------
module ddr_datapath_read
  import ddr_datapath_read_pkg::*;
#(
  parameter int CAS_LAT   = 3,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_start,
  input  logic [3:0]  cmd_state,
  input  logic [7:0]  ddr_dq_r,
  input  logic        ddr_dqs_r,
  output logic [15:0] sys_data_r,
  output logic        rd_valid,
  output logic        rd_done,
  output logic        rd_err,
  output logic        busy
);

  // WAIT_CL spends CAS_LAT-1 cycles; the count runs down to zero, so the
  // load value is one less. CAS_LAT==1 skips WAIT_CL entirely.
  localparam logic [3:0] CL_LOAD  = (CAS_LAT >= 2) ? 4'(CAS_LAT - 2) : 4'd0;
  localparam logic [3:0] LAST_IDX = 4'(BURST_LEN - 1);

  rd_state_e  state;
  logic [7:0] dq_q;
  logic       dqs_q;
  logic [3:0] cl_cnt;
  logic [3:0] byte_idx;
  logic       low_seen;

  logic in_window;
  logic cmd_abort;
  logic tmo_abort;
  logic abort;
  logic pre_hit;
  logic start_accept;
  logic byte_en;
  logic pack_clear;

  // Input stage: every decision below uses the registered bus values.
  // NOTE: state registers use non-blocking assignments so all flops update
  // together from pre-edge values; blocking here would create order races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dq_q  <= '0;
      dqs_q <= 1'b0;
    end else begin
      dq_q  <= ddr_dq_r;
      dqs_q <= ddr_dqs_r;
    end
  end

  assign in_window    = (state == ST_PREAMBLE) || (state == ST_CAPTURE);
  assign cmd_abort    = in_window && (cmd_state != C_WAIT_END_OF_R_BURST);
  // Byte 0 is the first strobe-high sample after a low seen in PREAMBLE.
  assign pre_hit      = (state == ST_PREAMBLE) && low_seen && dqs_q;
  assign start_accept = (state == ST_IDLE) && rd_start;

`ifdef READ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_cnt;

  // A preamble found on the last permitted cycle still wins.
  assign tmo_abort = (state == ST_PREAMBLE) && !pre_hit &&
                     (tmo_cnt == TW'(TIMEOUT - 1));
`else
  // TIMEOUT has no hardware in this build; keep it referenced.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign tmo_abort      = 1'b0;
`endif

  // Abort outranks byte capture, including the byte-0 and last-byte cycles.
  assign abort      = cmd_abort || tmo_abort;
  assign byte_en    = !abort && (pre_hit || (state == ST_CAPTURE));
  assign pack_clear = abort || start_accept;
  assign busy       = (state != ST_IDLE);

  // NOTE: every register, including pulse outputs, is cleared by the async
  // reset so a reset mid-burst drops all pulses immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cl_cnt   <= '0;
      byte_idx <= '0;
      low_seen <= 1'b0;
      rd_done  <= 1'b0;
      rd_err   <= 1'b0;
`ifdef READ_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else begin
      rd_done <= 1'b0;
      rd_err  <= 1'b0;
      if (abort) begin
        state    <= ST_IDLE;
        rd_err   <= 1'b1;
        low_seen <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (rd_start) begin
              low_seen <= 1'b0;
              cl_cnt   <= CL_LOAD;
`ifdef READ_TIMEOUT_EN
              tmo_cnt  <= '0;
`endif
              state    <= (CAS_LAT == 1) ? ST_PREAMBLE : ST_WAIT_CL;
            end
          end
          ST_WAIT_CL: begin
            if (cl_cnt == 4'd0) state  <= ST_PREAMBLE;
            else                cl_cnt <= cl_cnt - 4'd1;
          end
          ST_PREAMBLE: begin
            if (pre_hit) begin
              state    <= ST_CAPTURE;
              byte_idx <= 4'd1;
              low_seen <= 1'b0;
            end else begin
              if (!dqs_q) low_seen <= 1'b1;
`ifdef READ_TIMEOUT_EN
              tmo_cnt <= tmo_cnt + TW'(1);
`endif
            end
          end
          ST_CAPTURE: begin
            if (byte_idx == LAST_IDX) begin
              state   <= ST_DONE;
              rd_done <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  ddr_rd_word_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .byte_en    (byte_en),
    .byte_data  (dq_q),
    .sys_data_r (sys_data_r),
    .rd_valid   (rd_valid)
  );

endmodule

// File: tb/tb_ddr_datapath_read.sv
// ----------------------------------------------------------------------------
// tb_ddr_datapath_read
// Two instances: dut0 (BURST_LEN 8) and dut1 (BURST_LEN 2), each with its own
// inputs. Reads are planned as timelines: for each read the bench writes the
// raw input values per clock edge and the expected output values per edge,
// derived from the read's start edge, strobe-high edge and abort edge.
// Edge numbering: edge k is the k-th rising edge after reset release; an
// expectation at k is the output value seen just before edge k.
// Honours READ_TIMEOUT_EN for the stuck-preamble case.
// ----------------------------------------------------------------------------
module tb_ddr_datapath_read;
  import ddr_datapath_read_pkg::*;

  localparam int L   = 3;
  localparam int B0  = 8;
  localparam int B1  = 2;
  localparam int TMO = 16;
  localparam int N   = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        rd_start  [2];
  logic [3:0]  cmd_state [2];
  logic [7:0]  dq        [2];
  logic        dqs       [2];
  logic [15:0] o_data    [2];
  logic        o_valid   [2];
  logic        o_done    [2];
  logic        o_err     [2];
  logic        o_busy    [2];

  ddr_datapath_read #(.CAS_LAT(L), .BURST_LEN(B0), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .rst(rst), .rd_start(rd_start[0]), .cmd_state(cmd_state[0]),
    .ddr_dq_r(dq[0]), .ddr_dqs_r(dqs[0]), .sys_data_r(o_data[0]),
    .rd_valid(o_valid[0]), .rd_done(o_done[0]), .rd_err(o_err[0]),
    .busy(o_busy[0])
  );

  ddr_datapath_read #(.CAS_LAT(L), .BURST_LEN(B1), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .rst(rst), .rd_start(rd_start[1]), .cmd_state(cmd_state[1]),
    .ddr_dq_r(dq[1]), .ddr_dqs_r(dqs[1]), .sys_data_r(o_data[1]),
    .rd_valid(o_valid[1]), .rd_done(o_done[1]), .rd_err(o_err[1]),
    .busy(o_busy[1])
  );

  // Raw stimulus per DUT per edge.
  bit          st_start [2][N];
  logic [7:0]  st_dq    [2][N];
  bit          st_dqs   [2][N];
  logic [3:0]  st_cmd   [2][N];
  // Expected outputs per DUT per edge.
  bit          ex_valid [2][N];
  logic [15:0] ex_word  [2][N];
  bit          ex_done  [2][N];
  bit          ex_err   [2][N];
  bit          ex_busy  [2][N];

  logic [7:0]  byte_buf [16];
  logic [15:0] last_word [2];
  int cyc;
  int checks;
  int errors;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_from(input int k0);
    for (int d = 0; d < 2; d++) begin
      for (int k = k0; k < N; k++) begin
        st_start[d][k] = 1'b0;
        st_dq[d][k]    = 8'($urandom);
        st_dqs[d][k]   = 1'b1;
        st_cmd[d][k]   = C_IDLE;
        ex_valid[d][k] = 1'b0;
        ex_word[d][k]  = '0;
        ex_done[d][k]  = 1'b0;
        ex_err[d][k]   = 1'b0;
        ex_busy[d][k]  = 1'b0;
      end
    end
  endtask

  task automatic set_bytes(input bit seq);
    for (int k = 0; k < 16; k++)
      byte_buf[k] = seq ? 8'(17 * (k + 1)) : 8'($urandom);
  endtask

  // One read on DUT d started at edge t0. h: edge where the strobe is first
  // seen high after its low (0 = never). a: abort edge (0 = none); by_cmd
  // selects a cmd_state abort rather than a timeout. stop: last busy edge.
  task automatic plan_read(input int d, input int t0, input int h, input int a,
                           input bit by_cmd, input int blen, output int stop);
    bit completes;
    completes = (h != 0) && (a == 0);
    st_start[d][t0] = 1'b1;
    if (h != 0) begin
      for (int e = t0 + L; e < h; e++) st_dqs[d][e-1] = 1'b0;
      for (int k = 0; k < blen; k++) st_dq[d][h+k-1] = byte_buf[k];
    end
    stop = completes ? h + blen : a;
    for (int e = t0; e <= stop; e++) st_cmd[d][e] = C_WAIT_END_OF_R_BURST;
    if (!completes && by_cmd) st_cmd[d][a] = C_PRECHARGE;
    for (int e = t0 + 1; e <= stop; e++) ex_busy[d][e] = 1'b1;
    if (completes) ex_done[d][stop] = 1'b1;
    else           ex_err[d][a+1]   = 1'b1;
    if (h != 0) begin
      for (int j = 0; j < blen / 2; j++) begin
        if (completes || (h + 2*j + 1 < a)) begin
          ex_valid[d][h+2*j+2] = 1'b1;
          ex_word[d][h+2*j+2]  = {byte_buf[2*j], byte_buf[2*j+1]};
        end
      end
    end
  endtask

  task automatic check_all(input int k);
    for (int d = 0; d < 2; d++) begin
      if (ex_valid[d][k]) last_word[d] = ex_word[d][k];
      check($sformatf("dut%0d.rd_valid@%0d", d, k), 16'(o_valid[d]), 16'(ex_valid[d][k]));
      check($sformatf("dut%0d.sys_data_r@%0d", d, k), o_data[d], last_word[d]);
      check($sformatf("dut%0d.rd_done@%0d", d, k), 16'(o_done[d]), 16'(ex_done[d][k]));
      check($sformatf("dut%0d.rd_err@%0d", d, k), 16'(o_err[d]), 16'(ex_err[d][k]));
      check($sformatf("dut%0d.busy@%0d", d, k), 16'(o_busy[d]), 16'(ex_busy[d][k]));
    end
  endtask

  task automatic drive(input int k);
    for (int d = 0; d < 2; d++) begin
      rd_start[d]  = st_start[d][k];
      cmd_state[d] = st_cmd[d][k];
      dq[d]        = st_dq[d][k];
      dqs[d]       = st_dqs[d][k];
    end
  endtask

  // Runs from a falling edge up to the falling edge after edge n.
  task automatic run_to(input int n);
    while (cyc < n) begin
      check_all(cyc + 1);
      drive(cyc + 1);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_zero(input string when);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s dut%0d.sys_data_r", when, d), o_data[d], 16'h0000);
      check($sformatf("%s dut%0d.rd_valid", when, d), 16'(o_valid[d]), 16'h0);
      check($sformatf("%s dut%0d.rd_done", when, d), 16'(o_done[d]), 16'h0);
      check($sformatf("%s dut%0d.rd_err", when, d), 16'(o_err[d]), 16'h0);
      check($sformatf("%s dut%0d.busy", when, d), 16'(o_busy[d]), 16'h0);
    end
  endtask

  initial begin
    int t, h, s, s1, hr;
    checks = 0;
    errors = 0;
    cyc    = 0;
    last_word[0] = '0;
    last_word[1] = '0;
    clear_from(0);
    drive(0);

    // Reset state.
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // ---------------- dut0 (BURST_LEN 8) ----------------
    // Nominal read with bytes 11..88; extra rd_start in PREAMBLE and DONE.
    set_bytes(1'b1);
    t = 3;
    plan_read(0, t, t + 4, 0, 1'b1, B0, s);
    st_start[0][t+3] = 1'b1;
    st_start[0][s]   = 1'b1;

    // Back-to-back read with the preamble 5 cycles late.
    t = s + 1;
    set_bytes(1'b0);
    plan_read(0, t, t + 9, 0, 1'b1, B0, s);

    // Random reads: random gaps, preamble delays and data.
    for (int i = 0; i < 4; i++) begin
      t = s + 1 + int'($urandom_range(0, 3));
      h = t + 4 + int'($urandom_range(0, 5));
      set_bytes(1'b0);
      plan_read(0, t, h, 0, 1'b1, B0, s);
    end

    // Abort on byte index 3: only the first word survives.
    t = s + 1;
    set_bytes(1'b1);
    plan_read(0, t, t + 4, t + 7, 1'b1, B0, s);

    // Abort on the byte-0 cycle: no words.
    t = s + 1;
    set_bytes(1'b0);
    plan_read(0, t, t + 5, t + 5, 1'b1, B0, s);

    // Abort together with the last byte: three words, no rd_done.
    t = s + 1;
    set_bytes(1'b0);
    plan_read(0, t, t + 4, t + 11, 1'b1, B0, s);

    // Preamble never arrives.
    t = s + 2;
`ifdef READ_TIMEOUT_EN
    plan_read(0, t, 0, t + L + TMO - 1, 1'b0, B0, s);
`else
    plan_read(0, t, 0, t + L + 20, 1'b1, B0, s);
`endif

    // Read that will be cut by reset after byte 5.
    t  = s + 2;
    hr = t + 4;
    set_bytes(1'b0);
    plan_read(0, t, hr, 0, 1'b1, B0, s);

    // ---------------- dut1 (BURST_LEN 2) ----------------
    s1 = 2;
    for (int i = 0; i < 6; i++) begin
      t = s1 + 1;
      h = t + 4 + int'($urandom_range(0, 2));
      set_bytes(1'b0);
      plan_read(1, t, h, 0, 1'b1, B1, s1);
      st_start[1][t+1] = 1'b1;
      st_start[1][s1]  = 1'b1;
    end

    run_to(hr + 5);

    // Reset mid-CAPTURE: outputs drop at once, nothing pending afterwards.
    rst = 1'b0;
    #1;
    check_zero("mid-burst reset");
    clear_from(cyc + 1);
    last_word[0] = '0;
    last_word[1] = '0;
    run_to(cyc + 2);
    rst = 1'b1;

    // Nominal reads after reset on both instances.
    t = cyc + 2;
    set_bytes(1'b1);
    plan_read(0, t, t + 4, 0, 1'b1, B0, s);
    set_bytes(1'b0);
    plan_read(1, t, t + 4, 0, 1'b1, B1, s1);
    run_to(s + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
